// File: rtl/data_delay_pipe.sv
// data_delay_pipe
// Fixed-latency delay line that carries a valid/data token pair through
// LATENCY register stages. The stages advance together on ready_in, freeze
// when it is low, and are cleared by flush or rst. LATENCY=0 builds a
// combinational pass-through.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset
//   valid_in   in   token present at the input this cycle
//   data_in    in   payload accompanying valid_in
//   ready_in   in   advance enable; 0 freezes every stage
//   flush      in   synchronous kill of all in-flight tokens
//   valid_out  out  token present in the last stage
//   data_out   out  payload of the last stage
//   count      out  number of valid tokens held in the stages
//   empty      out  high when count is zero
module data_delay_pipe #(
  parameter int LATENCY    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ready_in,
  input  logic                  flush,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty
);

  if (LATENCY == 0) begin : g_passthru
    // No storage: clock, reset and advance enable have nothing to act on.
    logic w_unused;
    assign w_unused  = &{1'b0, clk, rst, ready_in};

    assign valid_out = valid_in & ~flush;
    assign data_out  = data_in;
    assign count     = '0;
    assign empty     = 1'b1;
  end else begin : g_pipe
    logic [LATENCY-1:0]    r_valid;
    logic [DATA_WIDTH-1:0] r_data [LATENCY];
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  w_count_next;

    // Entry and exit on the same advance edge cancel, so the counter tracks
    // the popcount of r_valid without a population-count tree.
    assign w_count_next = r_count + CNT_WIDTH'(valid_in)
                                  - CNT_WIDTH'(r_valid[LATENCY-1]);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= '0;
        r_count <= '0;
        for (int i = 0; i < LATENCY; i++) begin
          r_data[i] <= '0;
        end
      end else if (flush) begin
        // Data registers are left alone; only the valid bits matter.
        r_valid <= '0;
        r_count <= '0;
      end else if (ready_in) begin
        r_valid[0] <= valid_in;
        r_data[0]  <= data_in;
        for (int i = 1; i < LATENCY; i++) begin
          r_valid[i] <= r_valid[i-1];
          r_data[i]  <= r_data[i-1];
        end
        r_count <= w_count_next;
      end
    end

    assign valid_out = r_valid[LATENCY-1];
    assign data_out  = r_data[LATENCY-1];
    assign count     = r_count;
    assign empty     = (r_count == '0);
  end

endmodule
